lane_peak_select: RTL
=====================

Name: lane_peak_select

Overview:
Scans the Hough accumulator BRAM after voting finishes and finds the highest-vote (rho, theta) bin in a left-lane theta window and in a right-lane theta window. It drives the left/right rho/theta values and the `hough_done` pulse consumed by the lane highlight stage. It sits between the Hough voting/accumulation logic and the highlight stage, and reads the accumulator through one synchronous read port.

Parameters:
- THETA_BITS, 9, width of theta outputs (degrees 0..179)
- RHO_MAX, 1469, max |rho|; rho index = rho + RHO_MAX
- NUM_RHOS, 2*RHO_MAX+1, rho bins per theta row
- ACC_BITS, 16, accumulator word width
- ACC_ADDR_BITS, $clog2(180*NUM_RHOS), accumulator address width
- LEFT_THETA_MIN, 20, first left-lane theta (inclusive)
- LEFT_THETA_MAX, 70, last left-lane theta (inclusive)
- RIGHT_THETA_MIN, 110, first right-lane theta (inclusive)
- RIGHT_THETA_MAX, 160, last right-lane theta (inclusive)
- VOTE_THRESHOLD, 50, minimum votes for a lane peak to be accepted

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  accumulation complete; sampled only in IDLE
- acc_rd_addr  out  ACC_ADDR_BITS  accumulator address = theta*NUM_RHOS + rho_idx
- acc_rd_data  in  ACC_BITS  accumulator data, valid 1 cycle after address
- left_rho_out  out  16 signed  left lane rho
- left_theta_out  out  THETA_BITS  left lane theta
- right_rho_out  out  16 signed  right lane rho
- right_theta_out  out  THETA_BITS  right lane theta
- left_valid  out  1  left peak of last frame >= VOTE_THRESHOLD
- right_valid  out  1  right peak of last frame >= VOTE_THRESHOLD
- busy  out  1  high from LEFT_SCAN through COMMIT
- hough_done  out  1  single-cycle pulse: new outputs valid

Behaviour:
- Interface: one clock (`clock`). Reset (`reset`) is synchronous and active-high.
- Reset values:
  - all outputs 0; acc_rd_addr 0
  - state IDLE
  - best-vote/best-bin registers 0
- States:
  - IDLE -> LEFT_SCAN on start=1.
  - LEFT_SCAN: one address per cycle. Theta runs LEFT_THETA_MIN..MAX (outer loop); rho_idx runs 0..NUM_RHOS-1 (inner loop). After the last left address -> RIGHT_SCAN.
  - RIGHT_SCAN: same scan over the right theta window, with no bubble between windows. After the last address -> FLUSH.
  - FLUSH: one cycle; last read data is compared. -> COMMIT.
  - COMMIT: copies best registers to outputs. Sets valid flags (best_votes >= VOTE_THRESHOLD). hough_done is registered high. -> IDLE.
- Read pipeline:
  - Each issued address carries a registered tag (lane bit, theta, rho_idx) one cycle behind it, aligned with acc_rd_data.
  - Comparison uses the tag, never the current address.
- Compare rule:
  - Replace the lane's best only if data > best_votes (strict).
  - On ties, the first bin in scan order wins.
  - best_votes clears to 0 on start.
- Rho conversion: rho_out = signed(rho_idx) - RHO_MAX, in 16-bit two's complement.
- Below threshold:
  - That lane's rho/theta outputs keep the previous frame's values.
  - That lane's valid flag goes to 0.
  - hough_done still pulses.
- Output stability:
  - Outputs change only at the end of COMMIT, and all four values change together.
  - Outputs stay stable during the next scan, so highlight can run concurrently.
- Timing: with start sampled high at edge 0, N = (left window size + right window size) * NUM_RHOS.
  - Addresses are issued in cycles 1..N.
  - FLUSH is cycle N+1; COMMIT is cycle N+2.
  - hough_done=1 and new outputs appear in cycle N+3. Defaults: N = 102*2939 = 299778.
- start while not IDLE is ignored; it is not queued.
- Reset mid-scan:
  - Returns to IDLE next cycle, all outputs 0.
  - No hough_done pulse.
  - In-flight read data is discarded.
- Address arithmetic: theta*NUM_RHOS is held in an incrementally updated row-base register (add NUM_RHOS per theta step); no multiplier.

Decomposition:
- Shared package `hough_pkg`:
  - THETA_BITS, RHO_MAX, NUM_RHOS, ACC_BITS
  - theta window constants
  - function rho_idx_to_rho
  - typedef `acc_tag_t` {lane, theta, rho_idx}
- One natural sub-module, `lane_peak_tracker`: compare-and-hold of best votes/theta/rho_idx with clear input. Instantiate it twice, enabled by the tag lane bit.

Test Plan:
- Single left peak: accumulator all 0 except theta 40, rho_idx 1500 = 200.
  - Expect left_theta=40, left_rho=31, left_valid=1, right_valid=0.
  - Right outputs stay 0 from reset.
- Tie: theta 30/rho_idx 10 = 100 and theta 35/rho_idx 5 = 100.
  - Expect left_theta=30, left_rho=-1459.
  - Right: theta 120/rho_idx 2939... max index 2938 = 90. Expect right_theta=120, right_rho=1469.
- Threshold hold: frame 1 as in the single-peak test. Frame 2: all bins 49.
  - Expect left outputs unchanged (40/31), left_valid=0.
  - hough_done still pulses.
- Latency/handshake:
  - start at cycle 0 -> hough_done high exactly in cycle 299781, for one cycle.
  - busy is high in cycles 1..299780.
  - start pulses at cycle 1000 have no effect.
  - Bins outside both windows set to 1000 (e.g. theta 90) -> never selected.
- Reset mid-operation: assert reset at cycle 5000.
  - Expect IDLE, all outputs 0, no hough_done.
  - A new start then completes normally with correct peaks.

Source files
------------

// File: rtl/lane_peak_select_pkg.sv
// Shared Hough constants, tag type and rho conversion for the lane peak search.
package hough_pkg;
  localparam int unsigned THETA_BITS      = 9;
  localparam int unsigned RHO_MAX         = 1469;
  localparam int unsigned NUM_RHOS        = 2 * RHO_MAX + 1;
  localparam int unsigned ACC_BITS        = 16;
  localparam int unsigned ACC_ADDR_BITS   = $clog2(180 * NUM_RHOS);
  localparam int unsigned RHO_BITS        = 16;
  localparam int unsigned RHO_IDX_BITS    = $clog2(NUM_RHOS);
  localparam int unsigned LEFT_THETA_MIN  = 20;
  localparam int unsigned LEFT_THETA_MAX  = 70;
  localparam int unsigned RIGHT_THETA_MIN = 110;
  localparam int unsigned RIGHT_THETA_MAX = 160;
  localparam int unsigned VOTE_THRESHOLD  = 50;

  typedef logic [THETA_BITS-1:0]   theta_t;
  typedef logic [RHO_IDX_BITS-1:0] rho_idx_t;

  // Identifies the bin whose data returns one cycle after its address.
  typedef struct packed {
    logic     lane;
    theta_t   theta;
    rho_idx_t rho_idx;
  } acc_tag_t;

  function automatic logic signed [RHO_BITS-1:0] rho_idx_to_rho(input rho_idx_t idx,
                                                                input int unsigned rho_max);
    return $signed(RHO_BITS'(idx) - RHO_BITS'(rho_max));
  endfunction
endpackage

// File: rtl/lane_peak_select_if.sv
// Start, accumulator read port and lane results of the peak selector.
interface lane_peak_select_if #(
  parameter int unsigned ADDR_BITS = hough_pkg::ACC_ADDR_BITS
);
  import hough_pkg::*;

  logic                       start;
  logic [ADDR_BITS-1:0]       acc_rd_addr;
  logic [ACC_BITS-1:0]        acc_rd_data;
  logic signed [RHO_BITS-1:0] left_rho_out;
  theta_t                     left_theta_out;
  logic signed [RHO_BITS-1:0] right_rho_out;
  theta_t                     right_theta_out;
  logic                       left_valid;
  logic                       right_valid;
  logic                       busy;
  logic                       hough_done;

  modport master (
    input  start, acc_rd_data,
    output acc_rd_addr, left_rho_out, left_theta_out, right_rho_out, right_theta_out,
           left_valid, right_valid, busy, hough_done
  );

  modport slave (
    output start, acc_rd_data,
    input  acc_rd_addr, left_rho_out, left_theta_out, right_rho_out, right_theta_out,
           left_valid, right_valid, busy, hough_done
  );
endinterface

// File: rtl/lane_peak_select_tracker.sv
// Holds the highest vote count seen in one lane window; ties keep the earlier bin.
module lane_peak_tracker
  import hough_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [ACC_BITS-1:0] votes,
  input  theta_t              theta,
  input  rho_idx_t            rho_idx,
  output logic [ACC_BITS-1:0] best_votes,
  output theta_t              best_theta,
  output rho_idx_t            best_rho_idx
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      best_votes   <= '0;
      best_theta   <= '0;
      best_rho_idx <= '0;
    end else if (en && (votes > best_votes)) begin
      best_votes   <= votes;
      best_theta   <= theta;
      best_rho_idx <= rho_idx;
    end
  end

endmodule

// File: rtl/lane_peak_select.sv
// Scans the left and right theta windows of the Hough accumulator and commits
// the strongest bin of each lane once the scan drains.
module lane_peak_select #(
  parameter int unsigned RHO_MAX         = hough_pkg::RHO_MAX,
  parameter int unsigned LEFT_THETA_MIN  = hough_pkg::LEFT_THETA_MIN,
  parameter int unsigned LEFT_THETA_MAX  = hough_pkg::LEFT_THETA_MAX,
  parameter int unsigned RIGHT_THETA_MIN = hough_pkg::RIGHT_THETA_MIN,
  parameter int unsigned RIGHT_THETA_MAX = hough_pkg::RIGHT_THETA_MAX,
  parameter int unsigned VOTE_THRESHOLD  = hough_pkg::VOTE_THRESHOLD
) (
  input logic               clock,
  input logic               reset,
  lane_peak_select_if.master bus
);
  import hough_pkg::acc_tag_t;
  import hough_pkg::theta_t;
  import hough_pkg::rho_idx_t;
  import hough_pkg::rho_idx_to_rho;

  localparam int unsigned NUM_RHOS  = 2 * RHO_MAX + 1;
  localparam int unsigned ADDR_BITS = $clog2(180 * NUM_RHOS);
  localparam int unsigned TH_W      = hough_pkg::THETA_BITS;
  localparam int unsigned RI_W      = hough_pkg::RHO_IDX_BITS;
  localparam int unsigned ACC_W     = hough_pkg::ACC_BITS;

  localparam theta_t   L_MIN    = TH_W'(LEFT_THETA_MIN);
  localparam theta_t   L_MAX    = TH_W'(LEFT_THETA_MAX);
  localparam theta_t   R_MIN    = TH_W'(RIGHT_THETA_MIN);
  localparam theta_t   R_MAX    = TH_W'(RIGHT_THETA_MAX);
  localparam rho_idx_t RHO_LAST = RI_W'(NUM_RHOS - 1);
  localparam logic [ADDR_BITS-1:0] L_BASE   = ADDR_BITS'(LEFT_THETA_MIN * NUM_RHOS);
  localparam logic [ADDR_BITS-1:0] R_BASE   = ADDR_BITS'(RIGHT_THETA_MIN * NUM_RHOS);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(NUM_RHOS);
  localparam logic [ACC_W-1:0]     THRESH   = ACC_W'(VOTE_THRESHOLD);

  typedef enum logic [2:0] {IDLE, LEFT_SCAN, RIGHT_SCAN, FLUSH, COMMIT} state_t;

  state_t                 state;
  theta_t                 theta;
  rho_idx_t               rho_idx;
  logic [ADDR_BITS-1:0]   row_base;
  acc_tag_t               tag;
  logic                   tag_valid;
  logic                   start_accept_c;

  logic [ACC_W-1:0] l_votes, r_votes;
  theta_t           l_theta, r_theta;
  rho_idx_t         l_rho_idx, r_rho_idx;

  assign start_accept_c = (state == IDLE) && bus.start;

  lane_peak_tracker u_left (
    .clock(clock), .reset(reset), .clear(start_accept_c),
    .en(tag_valid && !tag.lane), .votes(bus.acc_rd_data),
    .theta(tag.theta), .rho_idx(tag.rho_idx),
    .best_votes(l_votes), .best_theta(l_theta), .best_rho_idx(l_rho_idx)
  );

  lane_peak_tracker u_right (
    .clock(clock), .reset(reset), .clear(start_accept_c),
    .en(tag_valid && tag.lane), .votes(bus.acc_rd_data),
    .theta(tag.theta), .rho_idx(tag.rho_idx),
    .best_votes(r_votes), .best_theta(r_theta), .best_rho_idx(r_rho_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      theta               <= '0;
      rho_idx             <= '0;
      row_base            <= '0;
      tag                 <= '0;
      tag_valid           <= 1'b0;
      bus.acc_rd_addr     <= '0;
      bus.left_rho_out    <= '0;
      bus.left_theta_out  <= '0;
      bus.right_rho_out   <= '0;
      bus.right_theta_out <= '0;
      bus.left_valid      <= 1'b0;
      bus.right_valid     <= 1'b0;
      bus.busy            <= 1'b0;
      bus.hough_done      <= 1'b0;
    end else begin
      hough_done_default();
      case (state)
        IDLE: begin
          if (bus.start) begin
            state           <= LEFT_SCAN;
            bus.busy        <= 1'b1;
            theta           <= L_MIN;
            rho_idx         <= '0;
            row_base        <= L_BASE;
            bus.acc_rd_addr <= L_BASE;
          end
        end
        LEFT_SCAN, RIGHT_SCAN: begin
          tag.lane    <= (state == RIGHT_SCAN);
          tag.theta   <= theta;
          tag.rho_idx <= rho_idx;
          tag_valid   <= 1'b1;
          if (rho_idx != RHO_LAST) begin
            rho_idx         <= rho_idx + 1'b1;
            bus.acc_rd_addr <= bus.acc_rd_addr + 1'b1;
          end else begin
            rho_idx <= '0;
            // Row base advances by one row per theta, so no multiply is needed.
            if ((state == LEFT_SCAN) && (theta == L_MAX)) begin
              state           <= RIGHT_SCAN;
              theta           <= R_MIN;
              row_base        <= R_BASE;
              bus.acc_rd_addr <= R_BASE;
            end else if ((state == RIGHT_SCAN) && (theta == R_MAX)) begin
              state <= FLUSH;
            end else begin
              theta           <= theta + 1'b1;
              row_base        <= row_base + ROW_STEP;
              bus.acc_rd_addr <= row_base + ROW_STEP;
            end
          end
        end
        FLUSH: state <= COMMIT;
        COMMIT: begin
          // A lane below threshold keeps its previous geometry but drops valid.
          if (l_votes >= THRESH) begin
            bus.left_rho_out   <= rho_idx_to_rho(l_rho_idx, RHO_MAX);
            bus.left_theta_out <= l_theta;
          end
          if (r_votes >= THRESH) begin
            bus.right_rho_out   <= rho_idx_to_rho(r_rho_idx, RHO_MAX);
            bus.right_theta_out <= r_theta;
          end
          bus.left_valid  <= (l_votes >= THRESH);
          bus.right_valid <= (r_votes >= THRESH);
          bus.hough_done  <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse and read-tag qualifiers default low each cycle; active states override.
  task automatic hough_done_default();
    bus.hough_done <= 1'b0;
    tag_valid      <= 1'b0;
  endtask

endmodule
